// File: rtl/fire_pkg.sv
// fire_pkg -- shared definitions for the fire event reporter.
//   * FSM state encoding (legacy 2-bit localparam constants behind a typedef)
//   * event record field widths / bit offsets
//   * the 24-bit record type {timestamp[15:0], evt_id[4:0], flag[2:0]}
//   * make_rec(): assembles a record from its fields
package fire_pkg;

    localparam int TS_W     = 16;
    localparam int ID_W     = 5;
    localparam int FLAG_W   = 3;
    localparam int REC_W    = TS_W + ID_W + FLAG_W;

    localparam int FLAG_LSB = 0;
    localparam int ID_LSB   = FLAG_LSB + FLAG_W;
    localparam int TS_LSB   = ID_LSB + ID_W;

    typedef logic [1:0] fire_state_t;

    localparam fire_state_t ST_IDLE    = 2'd0;
    localparam fire_state_t ST_CONFIRM = 2'd1;
    localparam fire_state_t ST_ACTIVE  = 2'd2;
    localparam fire_state_t ST_HOLDOFF = 2'd3;

    typedef struct packed {
        logic [TS_W-1:0]   timestamp;
        logic [ID_W-1:0]   evt_id;
        logic [FLAG_W-1:0] flag;
    } fire_rec_t;

    function automatic fire_rec_t make_rec(input logic [TS_W-1:0]   ts,
                                           input logic [ID_W-1:0]   id,
                                           input logic [FLAG_W-1:0] flag);
        fire_rec_t r;
        r.timestamp = ts;
        r.evt_id    = id;
        r.flag      = flag;
        return r;
    endfunction

endpackage

// File: rtl/fire_evt_fifo.sv
// fire_evt_fifo -- record buffer for the fire event reporter.
// Circular buffer of DEPTH records (DEPTH a power of two, 2..16). An
// occupancy counter, one bit wider than the pointers, separates full from
// empty; pointers wrap naturally modulo DEPTH.
// A push while full is accepted only if a pop happens in the same cycle
// (the slot being read is freed as the new record is written).
// rdata is the head record while non-empty and 0 while empty.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push, wdata  write request and record
//   pop          read request (ignored while empty)
//   rdata        head record
//   full, empty  occupancy status
module fire_evt_fifo
    import fire_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [REC_W-1:0] wdata,
    input  logic             pop,
    output logic [REC_W-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [REC_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [CW-1:0]    occ;
    logic             do_push;
    logic             do_pop;

    assign full    = (occ == CW'(DEPTH));
    assign empty   = (occ == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // Gate the read so stale storage never leaks out while empty.
    assign rdata   = empty ? '0 : mem[rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            occ  <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/fire_event_reporter.sv
// fire_event_reporter -- turns comparator samples into buffered event records.
// A confirm FSM (IDLE/CONFIRM/ACTIVE/HOLDOFF) watches det_output on cycles
// where det_valid=1. CONFIRM_SAMPLES consecutive asserted samples confirm an
// event and push one record {timestamp, evt_id, OR of the flags seen}. After
// confirmation the event must stay deasserted for HOLDOFF_CYCLES clocks
// before a new event can be reported; a reassertion during holdoff resumes
// the same event without a new record.
// Build option: define FIRE_REPORT_TIMESTAMP_EN to include the free-running
// 16-bit timestamp counter; without it evt_data[23:8] reads 0.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   det_valid             new comparator sample strobe
//   det_output, det_flag  reliable-event bit and per-sensor flags {T,S,H}
//   evt_valid, evt_ready  record handshake to the gateway
//   evt_data              {timestamp[15:0], evt_id[4:0], flag[2:0]}
//   drop_cnt              records lost to a full buffer (saturates at 255)
//   fifo_full             buffer holds FIFO_DEPTH records
//   dbg_state             current FSM state (fire_pkg ST_* encoding)
// Handshake: evt_valid/evt_ready follow strict valid/ready rules -- once
// evt_valid is high, evt_data holds still until the cycle evt_ready is also
// high, which is the one cycle the record is consumed.
module fire_event_reporter
    import fire_pkg::*;
#(
    parameter int CONFIRM_SAMPLES = 3,
    parameter int HOLDOFF_CYCLES  = 8,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             det_valid,
    input  logic             det_output,
    input  logic [2:0]       det_flag,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [REC_W-1:0] evt_data,
    output logic [7:0]       drop_cnt,
    output logic             fifo_full,
    output logic [1:0]       dbg_state
);

    fire_state_t       state, state_n;
    logic [3:0]        cnt, cnt_n;
    logic [4:0]        cnt_inc;
    logic [7:0]        hcnt, hcnt_n;
    logic [8:0]        hcnt_inc;
    logic [FLAG_W-1:0] acc, acc_n;
    logic [FLAG_W-1:0] push_flag;
    logic              push;
    logic              pop;
    logic              fifo_empty;
    logic              drop;
    logic [ID_W-1:0]   evt_id;
    logic [TS_W-1:0]   ts_now;
    fire_rec_t         rec;

`ifdef FIRE_REPORT_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ts_cnt <= '0;
        else        ts_cnt <= ts_cnt + 1'b1;
    end

    assign ts_now = ts_cnt;
`else
    assign ts_now = '0;
`endif

    assign cnt_inc  = {1'b0, cnt} + 5'd1;
    assign hcnt_inc = {1'b0, hcnt} + 9'd1;

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        acc_n     = acc;
        hcnt_n    = hcnt;
        push      = 1'b0;
        push_flag = acc;
        case (state)
            ST_IDLE: begin
                if (det_valid && det_output) begin
                    cnt_n = 4'd1;
                    acc_n = det_flag;
                    if (CONFIRM_SAMPLES == 1) begin
                        push      = 1'b1;
                        push_flag = det_flag;
                        state_n   = ST_ACTIVE;
                    end else begin
                        state_n = ST_CONFIRM;
                    end
                end
            end
            ST_CONFIRM: begin
                if (det_valid) begin
                    if (det_output) begin
                        cnt_n = cnt_inc[3:0];
                        acc_n = acc | det_flag;
                        // The confirming sample's flags are part of the record.
                        if (cnt_inc == 5'(CONFIRM_SAMPLES)) begin
                            push      = 1'b1;
                            push_flag = acc | det_flag;
                            state_n   = ST_ACTIVE;
                        end
                    end else begin
                        state_n = ST_IDLE;
                        cnt_n   = '0;
                        acc_n   = '0;
                    end
                end
            end
            ST_ACTIVE: begin
                if (det_valid && !det_output) begin
                    state_n = ST_HOLDOFF;
                    hcnt_n  = '0;
                end
            end
            ST_HOLDOFF: begin
                hcnt_n = hcnt_inc[7:0];
                // A reassertion wins over an expiring holdoff: same event.
                if (det_valid && det_output) begin
                    state_n = ST_ACTIVE;
                end else if (hcnt_inc == 9'(HOLDOFF_CYCLES)) begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                    acc_n   = '0;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            acc   <= '0;
            hcnt  <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            acc   <= acc_n;
            hcnt  <= hcnt_n;
        end
    end

    assign rec = make_rec(ts_now, evt_id, push_flag);

    assign evt_valid = !fifo_empty;
    assign pop       = evt_valid && evt_ready;
    // A pop in the same cycle frees the slot, so full+pop is not a drop.
    assign drop      = push && fifo_full && !pop;

    // evt_id counts every confirmation, dropped or not, so gaps reveal loss.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_id   <= '0;
            drop_cnt <= '0;
        end else begin
            if (push) evt_id <= evt_id + 1'b1;
            if (drop && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 1'b1;
        end
    end

    fire_evt_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (rec),
        .pop   (pop),
        .rdata (evt_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign dbg_state = state;

endmodule
